// File: rtl/led_pkg.sv
// Shared definitions for the LED frame sequencer: MAX7219 register map and FSM encodings.
package led_pkg;

  localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
  localparam logic [7:0] REG_DECODE    = 8'h09;
  localparam logic [7:0] REG_INTENSITY = 8'h0A;
  localparam logic [7:0] REG_SCANLIM   = 8'h0B;
  localparam logic [7:0] REG_TEST      = 8'h0F;

  typedef enum logic [2:0] {
    S_INIT_ADDR = 3'd0,
    S_INIT_DATA = 3'd1,
    S_HOLD      = 3'd2,
    S_IDLE      = 3'd3,
    S_ROW_ADDR  = 3'd4,
    S_ROW_DATA  = 3'd5,
    S_DONE      = 3'd6
  } state_t;

endpackage

// File: rtl/led_init_rom.sv
// Init command list for the MAX7219: index -> {register, data}, flagging the final entry.
module led_init_rom
  import led_pkg::*;
#(
  parameter logic [3:0] INTENSITY  = 4'h8,
  parameter logic [2:0] SCAN_LIMIT = 3'd7
) (
  input  logic [2:0] idx,
  output logic [7:0] addr,
  output logic [7:0] data,
  output logic       last
);

  always_comb begin
    addr = 8'h00;
    data = 8'h00;
    last = 1'b0;
    case (idx)
      3'd0: begin addr = REG_SHUTDOWN;  data = 8'h01; end
      3'd1: begin addr = REG_DECODE;    data = 8'h00; end
      3'd2: begin addr = REG_INTENSITY; data = {4'h0, INTENSITY}; end
      3'd3: begin addr = REG_SCANLIM;   data = {5'h00, SCAN_LIMIT}; end
      3'd4: begin addr = REG_TEST;      data = 8'h00; last = 1'b1; end
      default: last = 1'b1;
    endcase
  end

endmodule

// File: rtl/led_frame_sequencer.sv
// Feeds an SPI master with MAX7219 {register, data} pairs: one-time init, then one pair per
// display row for each accepted frame. Valid/ready: a byte is issued (o_TX_DV) only in a cycle
// where i_TX_Ready is high; the following cycle ignores ready because the master drops it late.
module led_frame_sequencer
  import led_pkg::*;
#(
  parameter logic [3:0] INTENSITY  = 4'h8,
  parameter logic [2:0] SCAN_LIMIT = 3'd7,
  parameter int         NUM_ROWS   = 8
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [63:0] i_Frame,
  input  logic        i_Frame_DV,
  output logic [1:0]  o_TX_Count,
  output logic [7:0]  o_TX_Byte,
  output logic        o_TX_DV,
  input  logic        i_TX_Ready,
  output logic        o_Init_Done,
  output logic        o_Busy,
  output logic        o_Frame_Done
);

  localparam logic [2:0] LAST_ROW = 3'(NUM_ROWS - 1);

  state_t      state_q, state_d;
  state_t      hold_q, hold_d;
  logic [2:0]  idx_q;
  logic [2:0]  row_q;
  logic [7:0]  byte_q;
  logic        init_done_q;
  logic        pending_q;
  logic [63:0] pending_frame_q;
  logic [63:0] active_q;

  logic        issue;
  logic [7:0]  issue_byte;
  logic        idx_inc;
  logic        row_inc;
  logic        pickup;

  logic [7:0]  rom_addr;
  logic [7:0]  rom_data;
  logic        rom_last;

  led_init_rom #(
    .INTENSITY  (INTENSITY),
    .SCAN_LIMIT (SCAN_LIMIT)
  ) u_rom (
    .idx  (idx_q),
    .addr (rom_addr),
    .data (rom_data),
    .last (rom_last)
  );

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    issue      = 1'b0;
    issue_byte = byte_q;
    idx_inc    = 1'b0;
    row_inc    = 1'b0;
    pickup     = 1'b0;
    case (state_q)
      S_INIT_ADDR: if (i_TX_Ready) begin
        issue      = 1'b1;
        issue_byte = rom_addr;
        state_d    = S_HOLD;
        hold_d     = S_INIT_DATA;
      end
      S_INIT_DATA: if (i_TX_Ready) begin
        issue      = 1'b1;
        issue_byte = rom_data;
        state_d    = S_HOLD;
        hold_d     = rom_last ? S_IDLE : S_INIT_ADDR;
        idx_inc    = ~rom_last;
      end
      S_HOLD: state_d = hold_q;
      // A strobe arriving in the pickup cycle is taken directly, bypassing the pending reg.
      S_IDLE: if (init_done_q && (pending_q || i_Frame_DV)) begin
        pickup  = 1'b1;
        state_d = S_ROW_ADDR;
      end
      S_ROW_ADDR: if (i_TX_Ready) begin
        issue      = 1'b1;
        issue_byte = {5'b00000, row_q} + 8'd1;
        state_d    = S_HOLD;
        hold_d     = S_ROW_DATA;
      end
      S_ROW_DATA: if (i_TX_Ready) begin
        issue      = 1'b1;
        issue_byte = active_q[{row_q, 3'b000} +: 8];
        state_d    = S_HOLD;
        hold_d     = (row_q == LAST_ROW) ? S_DONE : S_ROW_ADDR;
        row_inc    = (row_q != LAST_ROW);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_INIT_ADDR;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q         <= S_INIT_ADDR;
      hold_q          <= S_INIT_ADDR;
      idx_q           <= 3'd0;
      row_q           <= 3'd0;
      byte_q          <= 8'h00;
      init_done_q     <= 1'b0;
      pending_q       <= 1'b0;
      pending_frame_q <= 64'h0;
      active_q        <= 64'h0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      if (issue) byte_q <= issue_byte;
      if (idx_inc) idx_q <= idx_q + 3'd1;
      if (pickup) row_q <= 3'd0;
      else if (row_inc) row_q <= row_q + 3'd1;
      if (state_q == S_HOLD && hold_q == S_IDLE) init_done_q <= 1'b1;
      if (i_Frame_DV) pending_frame_q <= i_Frame;
      if (pickup) begin
        active_q  <= i_Frame_DV ? i_Frame : pending_frame_q;
        pending_q <= 1'b0;
      end else if (i_Frame_DV) begin
        pending_q <= 1'b1;
      end
    end
  end

  // Issue is combinational from ready, so reset must gate it to drop DV in the same cycle.
  assign o_TX_Count   = 2'd2;
  assign o_TX_DV      = issue & ~i_Rst;
  assign o_TX_Byte    = (issue & ~i_Rst) ? issue_byte : byte_q;
  assign o_Init_Done  = init_done_q;
  assign o_Busy       = ~i_Rst & ~((state_q == S_IDLE) & ~pending_q);
  assign o_Frame_Done = (state_q == S_DONE);

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed bench for led_frame_sequencer with a lagging-ready SPI master model and a byte scoreboard.
module tb_led_frame_sequencer;

  logic        clk;
  logic        rst;
  logic [63:0] i_Frame;
  logic        i_Frame_DV;
  logic [1:0]  o_TX_Count;
  logic [7:0]  o_TX_Byte;
  logic        o_TX_DV;
  logic        i_TX_Ready;
  logic        o_Init_Done;
  logic        o_Busy;
  logic        o_Frame_Done;

  logic [7:0]  exp_q[$];
  int          pass_cnt;
  int          total_cnt;
  int          fail_cnt;
  int          dv_cnt;
  int          fd_cnt;
  logic        stall;

  led_frame_sequencer dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_Frame      (i_Frame),
    .i_Frame_DV   (i_Frame_DV),
    .o_TX_Count   (o_TX_Count),
    .o_TX_Byte    (o_TX_Byte),
    .o_TX_DV      (o_TX_DV),
    .i_TX_Ready   (i_TX_Ready),
    .o_Init_Done  (o_Init_Done),
    .o_Busy       (o_Busy),
    .o_Frame_Done (o_Frame_Done)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_init();
    exp_q.push_back(8'h0C); exp_q.push_back(8'h01);
    exp_q.push_back(8'h09); exp_q.push_back(8'h00);
    exp_q.push_back(8'h0A); exp_q.push_back(8'h08);
    exp_q.push_back(8'h0B); exp_q.push_back(8'h07);
    exp_q.push_back(8'h0F); exp_q.push_back(8'h00);
  endtask

  task automatic push_frame(input logic [63:0] f);
    for (int r = 0; r < 8; r++) begin
      exp_q.push_back(8'(r + 1));
      exp_q.push_back(f[8*r +: 8]);
    end
  endtask

  task automatic strobe(input logic [63:0] f);
    i_Frame    = f;
    i_Frame_DV = 1'b1;
    tick();
    i_Frame_DV = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && o_Busy === 1'b0 && o_Init_Done === 1'b1) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_drain"}, 64'(n < budget), 64'd1);
  endtask

  task automatic wait_dv(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (dv_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_dv_wait"}, 64'(n < budget), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dv"},         64'(o_TX_DV),      64'd0);
    check({tag, "_byte"},       64'(o_TX_Byte),    64'd0);
    check({tag, "_count"},      64'(o_TX_Count),   64'd2);
    check({tag, "_init_done"},  64'(o_Init_Done),  64'd0);
    check({tag, "_busy"},       64'(o_Busy),       64'd0);
    check({tag, "_frame_done"}, 64'(o_Frame_Done), 64'd0);
  endtask

  // ---------------- master ready model ----------------
  // Ready stays high in the cycle after DV, then drops for 4 cycles.
  initial begin
    int   low_cnt;
    bit   drop_pend;
    bit   seen;
    logic model_ready;
    low_cnt     = 0;
    drop_pend   = 0;
    model_ready = 1'b1;
    i_TX_Ready  = 1'b1;
    forever begin
      @(negedge clk);
      seen = (o_TX_DV === 1'b1);
      @(posedge clk);
      #1;
      if (rst) begin
        model_ready = 1'b1;
        low_cnt     = 0;
        drop_pend   = 0;
      end else if (low_cnt > 0) begin
        low_cnt--;
        if (low_cnt == 0) model_ready = 1'b1;
      end else if (drop_pend) begin
        model_ready = 1'b0;
        low_cnt     = 4;
        drop_pend   = 0;
      end else if (seen) begin
        drop_pend = 1;
      end
      i_TX_Ready = model_ready && !stall;
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (o_TX_DV === 1'b1) begin
        dv_cnt++;
        check("tx_count", 64'(o_TX_Count), 64'd2);
        check("dv_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_b = exp_q.pop_front();
          check("tx_byte", 64'(o_TX_Byte), 64'(exp_b));
        end
      end
      if (o_Frame_Done === 1'b1) fd_cnt++;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [63:0] fa, fb, fc, fd, fe, ff;
    logic [7:0]  saved;
    int          base, base_fd, sdv, n;
    bit          changed;

    pass_cnt   = 0;
    total_cnt  = 0;
    fail_cnt   = 0;
    dv_cnt     = 0;
    fd_cnt     = 0;
    stall      = 1'b0;
    rst        = 1'b1;
    i_Frame    = 64'h0;
    i_Frame_DV = 1'b0;

    // 1: reset values, then the init list
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    push_init();
    base = dv_cnt;
    rst  = 1'b0;
    @(negedge clk);
    check("init_done_early", 64'(o_Init_Done), 64'd0);
    check("busy_in_init", 64'(o_Busy), 64'd1);
    wait_drain(400, "init");
    check("init_dv_count", 64'(dv_cnt - base), 64'd10);
    check("init_done", 64'(o_Init_Done), 64'd1);

    // 2: known frame, one-cycle pickup latency
    repeat (5) tick();
    base_fd = fd_cnt;
    base    = dv_cnt;
    fa      = 64'h8040201008040201;
    push_frame(fa);
    strobe(fa);
    @(negedge clk);
    check("pickup_latency_dv", 64'(o_TX_DV), 64'd1);
    check("busy_in_frame", 64'(o_Busy), 64'd1);
    wait_drain(600, "frame_a");
    check("frame_a_done_pulses", 64'(fd_cnt - base_fd), 64'd1);
    check("frame_a_dv_count", 64'(dv_cnt - base), 64'd16);
    check("frame_a_idle_busy", 64'(o_Busy), 64'd0);

    // 3: A then B strobed while C sends; A is overwritten
    fc = {$urandom, $urandom};
    fb = {$urandom, $urandom};
    ff = {$urandom, $urandom};
    base_fd = fd_cnt;
    base    = dv_cnt;
    push_frame(fc);
    strobe(fc);
    repeat (10) tick();
    strobe(ff);
    repeat ($urandom_range(2, 6)) tick();
    push_frame(fb);
    strobe(fb);
    wait_drain(1500, "frame_cb");
    repeat (40) tick();
    check("frame_cb_done_pulses", 64'(fd_cnt - base_fd), 64'd2);
    check("frame_cb_dv_count", 64'(dv_cnt - base), 64'd32);

    // 4: frame strobed 3 cycles after reset waits for init
    rst = 1'b1;
    tick();
    exp_q.delete();
    tick();
    push_init();
    base_fd = fd_cnt;
    base    = dv_cnt;
    rst     = 1'b0;
    repeat (3) tick();
    fd = {$urandom, $urandom};
    push_frame(fd);
    strobe(fd);
    wait_drain(1500, "init_then_frame");
    check("init_frame_dv_count", 64'(dv_cnt - base), 64'd26);
    check("init_frame_done_pulses", 64'(fd_cnt - base_fd), 64'd1);

    // 5: ready stuck low mid-row
    fe = {$urandom, $urandom};
    base_fd = fd_cnt;
    base    = dv_cnt;
    push_frame(fe);
    strobe(fe);
    wait_dv(base + 5, 400, "stall");
    stall = 1'b1;
    tick();
    saved   = o_TX_Byte;
    sdv     = dv_cnt;
    changed = 0;
    check("stall_held_byte", 64'(saved), 64'h03);
    repeat (50) begin
      @(negedge clk);
      if (o_TX_Byte !== saved) changed = 1;
    end
    check("stall_no_dv", 64'(dv_cnt - sdv), 64'd0);
    check("stall_byte_stable", 64'(changed), 64'd0);
    stall = 1'b0;
    tick();
    wait_drain(800, "stall_resume");
    check("stall_done_pulses", 64'(fd_cnt - base_fd), 64'd1);

    // 6: reset while the 6th row byte is on offer
    ff   = {$urandom, $urandom};
    base = dv_cnt;
    push_frame(ff);
    strobe(ff);
    wait_dv(base + 5, 400, "abort");
    n = 0;
    while (o_TX_DV !== 1'b1 && n < 200) begin
      #1;
      n++;
    end
    check("abort_dv_offered", 64'(n < 200), 64'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    exp_q.delete();
    repeat (3) tick();
    push_init();
    base = dv_cnt;
    rst  = 1'b0;
    wait_drain(400, "replay_init");
    check("replay_dv_count", 64'(dv_cnt - base), 64'd10);
    check("replay_init_done", 64'(o_Init_Done), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
